// File: rtl/mic_level_meter_pkg.sv
// Shared types and elaboration-time helpers for the microphone level meter.
package mic_level_meter_pkg;

   typedef enum logic [1:0] {
      MODE_BAR  = 2'b00,
      MODE_DOT  = 2'b01,
      MODE_SIGN = 2'b10,
      MODE_RSVD = 2'b11
   } mode_t;

   localparam int HOLD_W = 8;

   // Threshold for LED i: (i+1)/(num_leds+1) of full magnitude scale, rounded down.
   function automatic longint unsigned thr(input int i, input int mag_w, input int num_leds);
      longint unsigned full_s;
      full_s = 64'd1 << mag_w;
      return (64'(i + 1) * full_s) / 64'(num_leds + 1);
   endfunction

endpackage

// File: rtl/mic_level_meter_if.sv
// Sample stream from the microphone sampler into the level meter.
interface mic_level_meter_if #(
   parameter int SAMPLE_W = 18
);
   logic                sample_valid;
   logic [SAMPLE_W-1:0] sample;

   modport master (output sample_valid, output sample);
   modport slave  (input  sample_valid, input  sample);
endinterface

// File: rtl/mic_level_meter_sample_abs_sat.sv
// Combinational magnitude of a two's-complement sample, saturating the most-negative code.
module sample_abs_sat #(
   parameter int SAMPLE_W = 18
) (
   input  logic [SAMPLE_W-1:0] sample,
   output logic [SAMPLE_W-2:0] mag
);
   localparam int MAG_W = SAMPLE_W - 1;
   localparam logic [MAG_W-1:0] MAG_ONE = MAG_W'(1);

   logic [MAG_W-1:0] neg_s;

   assign neg_s = (~sample[MAG_W-1:0]) + MAG_ONE;

   // Most-negative code has no positive twin, so it clamps to full scale.
   always_comb begin
      if (!sample[SAMPLE_W-1]) begin
         mag = sample[MAG_W-1:0];
      end else if (sample[MAG_W-1:0] == '0) begin
         mag = '1;
      end else begin
         mag = neg_s;
      end
   end
endmodule

// File: rtl/mic_level_meter.sv
// Per-frame peak level meter driving an LED bar, bar with decaying hold dot, or sign bits.
module mic_level_meter
   import mic_level_meter_pkg::*;
#(
   parameter int SAMPLE_W    = 18,
   parameter int NUM_LEDS    = 10,
   parameter int FRAME_LEN   = 16,
   parameter int HOLD_FRAMES = 8,
   localparam int MAG_W      = SAMPLE_W - 1,
   localparam int LVL_W      = $clog2(NUM_LEDS + 1)
) (
   input  logic                clk_25,
   input  logic                rst_n,
   mic_level_meter_if.slave    smp,
   input  logic [1:0]          mode,
   output logic [NUM_LEDS-1:0] leds,
   output logic [LVL_W-1:0]    level,
   output logic [MAG_W-1:0]    peak,
   output logic                frame_strobe
);
   localparam int CNT_W = $clog2(FRAME_LEN);
   localparam logic [CNT_W-1:0]    CNT_LAST  = CNT_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0]    CNT_ONE   = CNT_W'(1);
   localparam logic [LVL_W-1:0]    LVL_ONE   = LVL_W'(1);
   localparam logic [NUM_LEDS-1:0] LED_ONE   = NUM_LEDS'(1);
   localparam logic [HOLD_W-1:0]   HOLD_INIT = HOLD_W'(HOLD_FRAMES);

   logic [MAG_W-1:0]    mag_s, max_s, mag_r, acc_r, frame_peak_r;
   logic [CNT_W-1:0]    cnt_r;
   logic                wrap_s, v1_r, last_r, done2_r;
   logic [NUM_LEDS-1:0] sign_sr_r, sign_frame_r, bar_s, dot_s, leds_nxt_s;
   logic [LVL_W-1:0]    new_lvl_s, hold_lvl_r, hold_lvl_nxt_s;
   logic [HOLD_W-1:0]   hold_cnt_r, hold_cnt_nxt_s;

   sample_abs_sat #(.SAMPLE_W(SAMPLE_W)) u_abs (
      .sample (smp.sample),
      .mag    (mag_s)
   );

   assign wrap_s = (cnt_r == CNT_LAST);
   assign max_s  = (mag_r > acc_r) ? mag_r : acc_r;

   // Stage 1: capture magnitude, frame position and per-sample sign bit.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         mag_r     <= '0;
         cnt_r     <= '0;
         v1_r      <= 1'b0;
         last_r    <= 1'b0;
         sign_sr_r <= '0;
      end else if (smp.sample_valid) begin
         mag_r  <= mag_s;
         v1_r   <= 1'b1;
         last_r <= wrap_s;
         cnt_r  <= wrap_s ? '0 : cnt_r + CNT_ONE;
         if (int'(cnt_r) < NUM_LEDS) begin
            sign_sr_r[cnt_r] <= smp.sample[SAMPLE_W-1];
         end
      end else begin
         v1_r   <= 1'b0;
         last_r <= 1'b0;
      end
   end

   // Stage 2: running peak; sign bits are snapshotted before the next frame overwrites them.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         acc_r        <= '0;
         frame_peak_r <= '0;
         sign_frame_r <= '0;
         done2_r      <= 1'b0;
      end else begin
         done2_r <= v1_r & last_r;
         if (v1_r) begin
            if (last_r) begin
               frame_peak_r <= max_s;
               sign_frame_r <= sign_sr_r;
               acc_r        <= '0;
            end else begin
               acc_r <= max_s;
            end
         end
      end
   end

   for (genvar g = 0; g < NUM_LEDS; g++) begin : g_thr
      localparam logic [MAG_W-1:0] THR_G = MAG_W'(thr(g, MAG_W, NUM_LEDS));
      assign bar_s[g] = (frame_peak_r >= THR_G);
   end

   // Stage 3 next-state: level, hold dot decay and LED pattern for the selected mode.
   always_comb begin
      new_lvl_s = '0;
      for (int i = 0; i < NUM_LEDS; i++) begin
         new_lvl_s = new_lvl_s + LVL_W'(bar_s[i]);
      end
      hold_lvl_nxt_s = hold_lvl_r;
      hold_cnt_nxt_s = hold_cnt_r;
      if (new_lvl_s >= hold_lvl_r) begin
         hold_lvl_nxt_s = new_lvl_s;
         hold_cnt_nxt_s = HOLD_INIT;
      end else if (hold_cnt_r != '0) begin
         hold_cnt_nxt_s = hold_cnt_r - 8'd1;
      end else if (hold_lvl_r != '0) begin
         hold_lvl_nxt_s = hold_lvl_r - LVL_ONE;
      end else begin
         hold_lvl_nxt_s = '0;
      end
      if (hold_lvl_nxt_s != '0) begin
         dot_s = LED_ONE << (hold_lvl_nxt_s - LVL_ONE);
      end else begin
         dot_s = '0;
      end
      case (mode_t'(mode))
         MODE_DOT:  leds_nxt_s = bar_s | dot_s;
         MODE_SIGN: leds_nxt_s = sign_frame_r;
         default:   leds_nxt_s = bar_s;
      endcase
   end

   // Stage 3: publish frame results and pulse the strobe.
   always_ff @(posedge clk_25 or negedge rst_n) begin
      if (!rst_n) begin
         leds         <= '0;
         level        <= '0;
         peak         <= '0;
         frame_strobe <= 1'b0;
         hold_lvl_r   <= '0;
         hold_cnt_r   <= '0;
      end else if (done2_r) begin
         leds         <= leds_nxt_s;
         level        <= new_lvl_s;
         peak         <= frame_peak_r;
         frame_strobe <= 1'b1;
         hold_lvl_r   <= hold_lvl_nxt_s;
         hold_cnt_r   <= hold_cnt_nxt_s;
      end else begin
         frame_strobe <= 1'b0;
      end
   end
endmodule

// File: tb/tb_mic_level_meter.sv
// Randomised and directed bench for mic_level_meter against a frame-level behavioural model.
module tb_mic_level_meter;
   localparam int SAMPLE_W    = 18;
   localparam int NUM_LEDS    = 10;
   localparam int FRAME_LEN   = 16;
   localparam int HOLD_FRAMES = 8;
   localparam int MAG_W       = SAMPLE_W - 1;
   localparam int FULL        = (1 << MAG_W) - 1;

   logic                clk_25 = 1'b0;
   logic                rst_n  = 1'b0;
   logic [1:0]          mode   = 2'b00;
   logic [NUM_LEDS-1:0] leds;
   logic [3:0]          level;
   logic [MAG_W-1:0]    peak;
   logic                frame_strobe;

   mic_level_meter_if #(.SAMPLE_W(SAMPLE_W)) smp_if ();

   mic_level_meter #(
      .SAMPLE_W(SAMPLE_W), .NUM_LEDS(NUM_LEDS), .FRAME_LEN(FRAME_LEN), .HOLD_FRAMES(HOLD_FRAMES)
   ) dut (
      .clk_25       (clk_25),
      .rst_n        (rst_n),
      .smp          (smp_if),
      .mode         (mode),
      .leds         (leds),
      .level        (level),
      .peak         (peak),
      .frame_strobe (frame_strobe)
   );

   always #20 clk_25 = ~clk_25;

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      int due;
      int pk;
      int sgn;
   } frame_t;

   frame_t pend[$];
   int ecnt = 0, idx = 0, fpk = 0, fsgn = 0, hold_lvl = 0, hold_cnt = 0;
   int exp_leds = 0, exp_level = 0, exp_peak = 0;
   bit exp_strobe = 1'b0;

   function automatic int thr_of(input int i);
      return ((i + 1) * (1 << MAG_W)) / (NUM_LEDS + 1);
   endfunction

   function automatic int mag_of(input logic [SAMPLE_W-1:0] s);
      int v;
      v = $signed(s);
      if (v < 0) v = -v;
      if (v > FULL) v = FULL;
      return v;
   endfunction

   // Frame-level model: collect each frame, then evaluate its outputs two edges after its last sample.
   initial begin : model_p
      frame_t f;
      int lvl, bar, m;
      forever begin
         @(posedge clk_25 or negedge rst_n);
         if (!rst_n) begin
            pend.delete();
            idx = 0; fpk = 0; fsgn = 0; hold_lvl = 0; hold_cnt = 0;
            exp_leds = 0; exp_level = 0; exp_peak = 0; exp_strobe = 1'b0;
         end else begin
            ecnt++;
            exp_strobe = 1'b0;
            if (pend.size() > 0 && pend[0].due == ecnt) begin
               f = pend.pop_front();
               lvl = 0;
               for (int i = 0; i < NUM_LEDS; i++) if (f.pk >= thr_of(i)) lvl++;
               bar = (1 << lvl) - 1;
               if (lvl >= hold_lvl) begin
                  hold_lvl = lvl; hold_cnt = HOLD_FRAMES;
               end else if (hold_cnt > 0) hold_cnt--;
               else if (hold_lvl > 0) hold_lvl--;
               case (mode)
                  2'b01:   exp_leds = bar | ((hold_lvl > 0) ? (1 << (hold_lvl - 1)) : 0);
                  2'b10:   exp_leds = f.sgn;
                  default: exp_leds = bar;
               endcase
               exp_level = lvl; exp_peak = f.pk; exp_strobe = 1'b1;
            end
            if (smp_if.sample_valid) begin
               m = mag_of(smp_if.sample);
               if (m > fpk) fpk = m;
               if (idx < NUM_LEDS && smp_if.sample[SAMPLE_W-1]) fsgn |= (1 << idx);
               idx++;
               if (idx == FRAME_LEN) begin
                  pend.push_back('{ecnt + 2, fpk, fsgn});
                  idx = 0; fpk = 0; fsgn = 0;
               end
            end
         end
      end
   end

   int strobe_cnt = 0, last_strobe = 0, gap = 0, cap_edge = 0;

   // Compare every output against the model on each falling edge.
   initial begin : compare_p
      forever begin
         @(negedge clk_25);
         check("strobe", frame_strobe, exp_strobe);
         check("leds", leds, exp_leds);
         check("level", level, exp_level);
         check("peak", peak, exp_peak);
         if (frame_strobe) begin
            strobe_cnt++;
            gap = ecnt - last_strobe;
            last_strobe = ecnt;
            cap_edge = ecnt;
         end
      end
   end

   task automatic drive(input logic v, input logic [SAMPLE_W-1:0] s);
      @(negedge clk_25);
      smp_if.sample_valid = v;
      smp_if.sample = s;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) drive(1'b0, 18'd0);
   endtask

   // One frame whose largest magnitude is exactly pk; the others are random at or below it.
   task automatic frame_with_peak(input int pk);
      int pos, mg, s;
      pos = $urandom_range(0, FRAME_LEN - 1);
      for (int i = 0; i < FRAME_LEN; i++) begin
         mg = (i == pos) ? pk : $urandom_range(0, pk);
         s = ($urandom_range(0, 1) == 1) ? -mg : mg;
         drive(1'b1, SAMPLE_W'(s));
      end
      idle(4);
   endtask

   int t_acc, s0;
   int pks [3] = '{11915, 11914, 119156};
   int lvls[3] = '{1, 0, 10};
   int ledv[3] = '{1, 0, 1023};
   int r;
   logic v;
   logic [SAMPLE_W-1:0] s;

   initial begin : stim_p
      smp_if.sample_valid = 1'b0;
      smp_if.sample = '0;
      repeat (3) @(negedge clk_25);
      check("rst_leds", leds, 0);
      check("rst_level", level, 0);
      check("rst_peak", peak, 0);
      check("rst_strobe", frame_strobe, 0);
      rst_n = 1'b1;
      idle(2);

      // Most-negative sample saturates to full scale.
      for (int i = 0; i < FRAME_LEN; i++) drive(1'b1, (i == 5) ? 18'h20000 : 18'd0);
      @(posedge clk_25);
      #1 t_acc = ecnt;
      idle(4);
      check("t1_peak", peak, 131071);
      check("t1_level", level, 10);
      check("t1_leds", leds, 10'h3FF);
      check("t1_latency", cap_edge - t_acc, 2);
      check("t1_model_peak", exp_peak, 131071);
      check("t1_model_level", exp_level, 10);

      for (int k = 0; k < 3; k++) begin
         frame_with_peak(pks[k]);
         check("t2_leds", leds, ledv[k]);
         check("t2_level", level, lvls[k]);
      end

      mode = 2'b01;
      frame_with_peak(FULL);
      check("t3_full", leds, 10'h3FF);
      for (int f = 1; f <= 10; f++) begin
         frame_with_peak(0);
         check("t3_hold", leds, (f <= 8) ? 10'h200 : ((f == 9) ? 10'h100 : 10'h080));
         if (f == 9) check("t3_model_dot", exp_leds, 10'h100);
      end

      mode = 2'b10;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < FRAME_LEN; i++) drive(1'b1, (i % 2 == 0) ? 18'd1 : 18'h3FFFF);
         idle(4);
         check("t4_sign", leds, 10'h2AA);
      end

      mode = 2'b00;
      s0 = strobe_cnt;
      for (int i = 0; i < 64; i++) drive(1'b1, SAMPLE_W'($urandom));
      idle(4);
      check("t5_count", strobe_cnt - s0, 4);
      check("t5_gap", gap, 16);
      s0 = strobe_cnt;
      for (int i = 0; i < 128; i++) drive(i % 2 == 0, SAMPLE_W'($urandom));
      idle(4);
      check("t5_toggle_count", strobe_cnt - s0, 4);
      check("t5_toggle_gap", gap, 32);

      for (int i = 0; i < 7; i++) drive(1'b1, 18'd120000);
      drive(1'b0, 18'd0);
      #5 rst_n = 1'b0;
      #2;
      check("t6_rst_leds", leds, 0);
      check("t6_rst_level", level, 0);
      check("t6_rst_peak", peak, 0);
      #3 rst_n = 1'b1;
      for (int i = 0; i < FRAME_LEN; i++) drive(1'b1, 18'd20000);
      idle(4);
      check("t6_peak", peak, 20000);
      check("t6_level", level, 1);
      check("t6_leds", leds, 10'h001);

      // Random traffic with mode changes and one asynchronous reset pulse.
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < 3) mode = 2'($urandom_range(0, 3));
         v = ($urandom_range(0, 3) != 0);
         r = $urandom_range(0, 9);
         if (r == 0) s = 18'h20000;
         else if (r == 1) s = 18'h1FFFF;
         else if (r == 2) s = SAMPLE_W'($urandom_range(0, 40000));
         else s = SAMPLE_W'($urandom);
         drive(v, s);
         if (c == 1500) begin
            #5 rst_n = 1'b0;
            #5 rst_n = 1'b1;
         end
      end
      idle(4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
